// File: rtl/sift_pkg.sv
// Shared types and defaults for the SIFT Gaussian-stage window sequencer.
package sift_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } scan_state_t;

    localparam int IMG_W_DEF  = 512;
    localparam int IMG_H_DEF  = 512;
    localparam int WIN_DEF    = 11;
    localparam int CENTER_OFS = (WIN_DEF - 1) / 2;

    // Offset from the newest pixel of a window to its centre, for any odd size.
    function automatic int center_ofs(input int win);
        return (win - 1) / 2;
    endfunction

endpackage

// File: rtl/raster_coord_cnt.sv
// Raster column/row counter: column wraps at COLS-1 and carries into row.
module raster_coord_cnt #(
    parameter int COLS    = 512,
    parameter int ROWS    = 512,
    parameter int COORD_W = 9
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_clr,
    input  logic               i_en,
    output logic [COORD_W-1:0] o_col,
    output logic [COORD_W-1:0] o_row
);

    localparam logic [COORD_W-1:0] COL_LAST = COORD_W'(COLS - 1);
    localparam logic [COORD_W-1:0] ROW_LAST = COORD_W'(ROWS - 1);

    logic [COORD_W-1:0] r_col;
    logic [COORD_W-1:0] r_row;

    // Clear has priority; otherwise advance one pixel per enable.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (i_clr) begin
            r_col <= '0;
            r_row <= '0;
        end else if (i_en) begin
            if (r_col == COL_LAST) begin
                r_col <= '0;
                r_row <= (r_row == ROW_LAST) ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    assign o_col = r_col;
    assign o_row = r_row;

endmodule

// File: rtl/window_scan_ctrl.sv
// Frame sequencer for the 11x11 window generator: issues raster RAM reads,
// pushes returned pixels with shift_en and flags fully interior windows.
// Optional macro SCAN_PERF_EN adds a stall_cycles counter output.
//
// Handshake: start is accepted only in IDLE; hold (downstream not ready)
// suppresses new reads in RUN, while a read already in flight is still
// pushed one cycle later, so no pixel is dropped or duplicated.
module window_scan_ctrl
    import sift_pkg::*;
#(
    parameter int IMG_W   = IMG_W_DEF,
    parameter int IMG_H   = IMG_H_DEF,
    parameter int WIN     = WIN_DEF,
    parameter int ADDR_W  = 18,
    parameter int COORD_W = 9
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               hold,
    output logic               busy,
    output logic               ram_rd_en,
    output logic [ADDR_W-1:0]  ram_addr,
    output logic               shift_en,
    output logic               win_valid,
    output logic [COORD_W-1:0] win_row,
    output logic [COORD_W-1:0] win_col,
    output logic               done
`ifdef SCAN_PERF_EN
    ,
    output logic [31:0]        stall_cycles
`endif
);

    localparam int                 NPIX      = IMG_W * IMG_H;
    localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(NPIX - 1);
    localparam logic [COORD_W-1:0] EDGE      = COORD_W'(WIN - 1);
    localparam logic [COORD_W-1:0] OFS       = COORD_W'(center_ofs(WIN));

    scan_state_t        r_state;
    scan_state_t        w_next;
    logic               w_rd_en;
    logic               w_start_acc;
    logic [ADDR_W-1:0]  r_addr;
    logic               r_shift_en;
    logic               r_win_valid;
    logic [COORD_W-1:0] r_win_row;
    logic [COORD_W-1:0] r_win_col;
    logic [COORD_W-1:0] w_col_in;
    logic [COORD_W-1:0] w_row_in;
    logic               w_interior;

    assign w_start_acc = (r_state == IDLE) && start;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and read strobe; DRAIN waits for the last pixel's push.
    always_comb begin
        w_next  = r_state;
        w_rd_en = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next = RUN;
                end
            end
            RUN: begin
                w_rd_en = !hold;
                if (!hold && (r_addr == LAST_ADDR)) begin
                    w_next = DRAIN;
                end
            end
            DRAIN: begin
                if (!r_shift_en) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Read address: cleared at frame start, stops at the last pixel.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr <= '0;
        end else if (w_start_acc) begin
            r_addr <= '0;
        end else if (w_rd_en && (r_addr != LAST_ADDR)) begin
            r_addr <= r_addr + 1'b1;
        end
    end

    // One-cycle RAM latency: data arrives the cycle after the read strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shift_en <= 1'b0;
        end else begin
            r_shift_en <= w_rd_en;
        end
    end

    raster_coord_cnt #(
        .COLS    (IMG_W),
        .ROWS    (IMG_H),
        .COORD_W (COORD_W)
    ) u_in_coord (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_start_acc),
        .i_en  (r_shift_en),
        .o_col (w_col_in),
        .o_row (w_row_in)
    );

    // A window is interior once the pushed pixel has WIN-1 rows and columns behind it.
    assign w_interior = (w_row_in >= EDGE) && (w_col_in >= EDGE);

    // Register validity with the centre coordinate; centre holds between windows.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_win_valid <= 1'b0;
            r_win_row   <= '0;
            r_win_col   <= '0;
        end else begin
            r_win_valid <= r_shift_en && w_interior;
            if (r_shift_en && w_interior) begin
                r_win_row <= w_row_in - OFS;
                r_win_col <= w_col_in - OFS;
            end
        end
    end

`ifdef SCAN_PERF_EN
    logic [31:0] r_stall_cycles;

    // Count stalled RUN cycles; saturating, cleared at frame start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cycles <= '0;
        end else if (w_start_acc) begin
            r_stall_cycles <= '0;
        end else if ((r_state == RUN) && hold && (r_stall_cycles != 32'hFFFF_FFFF)) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign stall_cycles = r_stall_cycles;
`endif

    assign busy      = (r_state == RUN) || (r_state == DRAIN);
    assign done      = (r_state == DONE);
    assign ram_rd_en = w_rd_en;
    assign ram_addr  = r_addr;
    assign shift_en  = r_shift_en;
    assign win_valid = r_win_valid;
    assign win_row   = r_win_row;
    assign win_col   = r_win_col;

endmodule

// File: doc/window_scan_ctrl.md
Name: window_scan_ctrl

Overview:
- Frame sequencer for the 11x11 line-buffer/shift-register window generator in the SIFT Gaussian stage.
- On a start handshake, issues raster-order read addresses to the image RAM and pushes returned pixels into the window generator via a shift enable.
- Tracks input coordinates and flags when the 11x11 window is fully interior (valid), reporting its centre coordinate.
- Supports downstream back-pressure and signals frame completion; replaces free-running address counting and fixed-count start thresholds.

Parameters:
- IMG_W, 512, image width in pixels (>= WIN)
- IMG_H, 512, image height in pixels (>= WIN)
- WIN, 11, window size (odd)
- ADDR_W, 18, RAM address width (2^ADDR_W >= IMG_W*IMG_H)
- COORD_W, 9, row/column coordinate width (2^COORD_W >= max(IMG_W, IMG_H))

Ports:
- clk  in  1  clock
- rst  in  1  reset (asynchronous, active-low)
- start  in  1  frame start request; sampled only in IDLE
- hold  in  1  downstream not ready; suppresses new RAM reads
- busy  out  1  high from the cycle after start is accepted until done
- ram_rd_en  out  1  RAM read strobe
- ram_addr  out  ADDR_W  RAM read address
- shift_en  out  1  push RAM data into window generator this cycle
- win_valid  out  1  window outputs hold a full interior window
- win_row  out  COORD_W  centre row of valid window
- win_col  out  COORD_W  centre column of valid window
- done  out  1  one-cycle frame-complete pulse

Behaviour:
- Reset state: state=IDLE; all outputs 0; all counters 0.
- States: IDLE, RUN, DRAIN, DONE.
  - IDLE -> RUN when start=1.
  - RUN -> DRAIN in the cycle after the read of address IMG_W*IMG_H-1 issues.
  - DRAIN -> DONE once the last shift_en and its win_valid have occurred.
  - DONE -> IDLE unconditionally; done=1 only in DONE.
- start is ignored while busy=1. start held high in DONE/IDLE begins a new frame the cycle after returning to IDLE.
- Reads:
  - In RUN, ram_rd_en = !hold.
  - ram_addr increments by 1 after each issued read. Address runs 0..IMG_W*IMG_H-1 and does not wrap.
  - The first read issues the cycle after start is accepted.
- RAM latency is 1 cycle: shift_en = ram_rd_en delayed 1 cycle. The in-flight pixel is always pushed, even if hold rises.
- Input coordinates (col_in, row_in):
  - Advance on each shift_en.
  - col_in wraps IMG_W-1 -> 0 and increments row_in.
  - Both clear at frame start.
- Window validity:
  - win_valid is registered: it asserts the cycle after a shift_en whose pixel satisfies row_in >= WIN-1 and col_in >= WIN-1.
  - win_row = row_in-(WIN-1)/2 and win_col = col_in-(WIN-1)/2, registered with win_valid.
  - win_row/win_col hold their last value when win_valid=0.
- Window count per frame is exactly (IMG_W-WIN+1)*(IMG_H-WIN+1).
  - Windows straddling the row wrap (col_in < WIN-1) are never flagged.
- hold:
  - Stalls address generation only. No pixel is dropped or duplicated.
  - hold during DRAIN/DONE/IDLE has no effect.
- Async reset mid-frame returns immediately to IDLE with all outputs 0. No done is produced for the aborted frame.

Optional Feature:
- SCAN_PERF_EN
  - Defined: adds output stall_cycles [31:0]. It counts RUN cycles with hold=1, clears at frame start, saturates at 2^32-1, holds after done, and resets to 0.
  - Undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package sift_pkg:
  - state enum (IDLE, RUN, DRAIN, DONE)
  - default IMG_W/IMG_H/WIN constants
  - CENTER_OFS = (WIN-1)/2
- One natural sub-module: raster_coord_cnt. It is a column/row counter with wrap, enable and clear, instantiated for the input coordinates.

Test Plan:
- Basic frame (IMG_W=16, IMG_H=12, no hold), start pulse at cycle 0:
  - ram_rd_en cycles 1..192, ram_addr 0..191, shift_en cycles 2..193.
  - Exactly 12 win_valid pulses; first centre (5,5), last (6,10).
  - done single pulse, busy low after it.
- Random hold (30% duty) on same frame: exactly 192 shift_en, addresses strictly sequential with no repeats, same 12 window coordinates in the same order as the basic frame.
- Row-wrap check: no win_valid for col_in 0..9 of any row; win_col never < 5 or > 10.
- start asserted while busy at cycles 50 and 100: ignored, single done. Back-to-back start held high: second frame's ram_addr restarts at 0 the cycle after IDLE.
- rst low at cycle 80: all outputs 0 immediately, no done. A new start after release yields a full correct frame.
- SCAN_PERF_EN defined, hold high for exactly 37 RUN cycles: stall_cycles=37 after done, cleared to 0 at next start.
